// File: rtl/compensation_weight_generator_pkg.sv
// Shared definitions for the compensation weight generator and the
// compensation memory it feeds: array geometry, weight split widths,
// slot-group sizing and the load FSM state encoding.
package compensation_weight_generator_pkg;

  localparam int SIZE       = 8;  // rows per column and number of columns
  localparam int W_WIDTH    = 8;  // raw weight width
  localparam int COMP_WIDTH = 3;  // residual (low bits) width
  localparam int MAX_COMP   = 3;  // compensation slots per column downstream

  localparam int TRUNC_WIDTH     = W_WIDTH - COMP_WIDTH;
  localparam int SLOT_GROUP_SIZE = SIZE * MAX_COMP;  // total downstream slots
  localparam int IDX_WIDTH       = $clog2(SIZE);
  localparam int SLOT_CNT_WIDTH  = $clog2(MAX_COMP + 1);

  localparam logic [IDX_WIDTH-1:0]      LAST_IDX  = IDX_WIDTH'(SIZE - 1);
  localparam logic [SLOT_CNT_WIDTH-1:0] SLOT_FULL = SLOT_CNT_WIDTH'(MAX_COMP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/comp_slot_counter.sv
// Per-column residual slot counter. Tracks how many compensation values the
// current column has already emitted and decides, for each transfer, whether
// a nonzero residual is emitted or dropped, and whether the column-end
// change_col must be suppressed because the downstream index is already
// aligned to the next slot group.
//
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   clear            start of a new load; empties the counter
//   fire             a weight is transferred this cycle
//   nonzero          residual of the transferred weight is nonzero
//   col_end          transferred weight is the last row of its column
//   emit             store this residual downstream
//   drop             discard this residual (column full)
//   suppress_change  column already used all slots; no change_col needed
module comp_slot_counter
  import compensation_weight_generator_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic fire,
  input  logic nonzero,
  input  logic col_end,
  output logic emit,
  output logic drop,
  output logic suppress_change
);

  logic [SLOT_CNT_WIDTH-1:0] comp_cnt;
  logic                      full;

  assign full            = (comp_cnt == SLOT_FULL);
  assign emit            = fire & nonzero & ~full;
  assign drop            = fire & nonzero & full;
  assign suppress_change = full;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      comp_cnt <= '0;
    end else if (clear) begin
      comp_cnt <= '0;
    end else if (fire) begin
      if (col_end)
        comp_cnt <= '0;
      else if (emit)
        comp_cnt <= comp_cnt + SLOT_CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/compensation_weight_generator.sv
// Compensation weight generator: accepts a SIZE*SIZE column-major weight
// stream, forwards the truncated high bits to the main weight path and emits
// nonzero low-bit residuals (at most MAX_COMP per column) to the compensation
// memory, along with column-change and done controls that keep the memory's
// write index aligned to MAX_COMP-slot groups. All outputs are registered,
// one cycle after the transfer.
//
// Ports:
//   clk, rst                clock, asynchronous active-low reset
//   start                   pulse; begins a new load (ignored while loading)
//   in_weight/_valid/_ready raw weight stream handshake
//   out_Weight/_valid       truncated weight, in_weight[W_WIDTH-1:COMP_WIDTH]
//   Compensation_Weight     residual, in_weight[COMP_WIDTH-1:0]
//   out_Compensation_valid  residual is to be stored
//   change_col              advance downstream index to next slot group
//   done                    load complete (level)
//   drop_cnt                saturating count of residuals lost to full columns
module compensation_weight_generator
  import compensation_weight_generator_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [W_WIDTH-1:0]     in_weight,
  input  logic                   in_weight_valid,
  output logic                   in_weight_ready,
  output logic [TRUNC_WIDTH-1:0] out_Weight,
  output logic                   out_Weight_valid,
  output logic [COMP_WIDTH-1:0]  Compensation_Weight,
  output logic                   out_Compensation_valid,
  output logic                   change_col,
  output logic                   done,
  output logic [7:0]             drop_cnt
);

  state_t               state, next_state;
  logic [IDX_WIDTH-1:0] row_cnt, col_cnt;
  logic                 fire, col_end, last_xfer, start_load;
  logic                 emit, drop, suppress_change;

  assign fire       = (state == ST_RUN) & in_weight_valid;
  assign col_end    = (row_cnt == LAST_IDX);
  assign last_xfer  = fire & col_end & (col_cnt == LAST_IDX);
  assign start_load = start & (state != ST_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    next_state      = state;
    in_weight_ready = 1'b0;
    case (state)
      ST_IDLE: if (start) next_state = ST_RUN;
      ST_RUN: begin
        in_weight_ready = 1'b1;
        if (last_xfer) next_state = ST_DONE;
      end
      ST_DONE: if (start) next_state = ST_RUN;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (start_load) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (fire) begin
      if (col_end) begin
        row_cnt <= '0;
        col_cnt <= col_cnt + IDX_WIDTH'(1);
      end else begin
        row_cnt <= row_cnt + IDX_WIDTH'(1);
      end
    end
  end

  comp_slot_counter u_slot_counter (
    .clk             (clk),
    .rst             (rst),
    .clear           (start_load),
    .fire            (fire),
    .nonzero         (|in_weight[COMP_WIDTH-1:0]),
    .col_end         (col_end),
    .emit            (emit),
    .drop            (drop),
    .suppress_change (suppress_change)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_Weight             <= '0;
      Compensation_Weight    <= '0;
      out_Weight_valid       <= 1'b0;
      out_Compensation_valid <= 1'b0;
      change_col             <= 1'b0;
      drop_cnt               <= '0;
      done                   <= 1'b0;
    end else begin
      out_Weight_valid       <= fire;
      out_Compensation_valid <= emit;
      // A full column already left the downstream index on the next group
      // boundary; another change_col would skip a whole slot group.
      change_col             <= fire & col_end & ~suppress_change;
      // Data outputs hold between transfers.
      if (fire) begin
        out_Weight          <= in_weight[W_WIDTH-1:COMP_WIDTH];
        Compensation_Weight <= in_weight[COMP_WIDTH-1:0];
      end
      if (start_load)
        drop_cnt <= '0;
      else if (drop && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      // done rises one cycle after the final outputs so the last store is
      // never masked, and falls in the cycle after a restart.
      done <= (state == ST_DONE) & ~start;
    end
  end

endmodule

// File: tb/tb_compensation_weight_generator.sv
// Self-checking bench for compensation_weight_generator. A transfer-level
// reference model computes expected outputs from each column's weights;
// a compare process checks every cycle, and directed loads pin the model
// with hand-computed values (emit/drop counts, downstream slot index).
module tb_compensation_weight_generator;
  import compensation_weight_generator_pkg::*;

  typedef logic [7:0] load_t [64];
  typedef struct packed {
    logic [4:0] w;
    logic [2:0] c;
    logic       cv;
    logic       cc;
  } out_t;

  logic                   clk, rst, start;
  logic [W_WIDTH-1:0]     in_weight;
  logic                   in_weight_valid, in_weight_ready;
  logic [TRUNC_WIDTH-1:0] out_Weight;
  logic                   out_Weight_valid;
  logic [COMP_WIDTH-1:0]  Compensation_Weight;
  logic                   out_Compensation_valid, change_col, done;
  logic [7:0]             drop_cnt;

  compensation_weight_generator dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .in_weight              (in_weight),
    .in_weight_valid        (in_weight_valid),
    .in_weight_ready        (in_weight_ready),
    .out_Weight             (out_Weight),
    .out_Weight_valid       (out_Weight_valid),
    .Compensation_Weight    (Compensation_Weight),
    .out_Compensation_valid (out_Compensation_valid),
    .change_col             (change_col),
    .done                   (done),
    .drop_cnt               (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model (transfer level) ----------------
  logic [7:0] m_col [SIZE];
  int         m_k, e_drop;
  bit         m_loading, m_finished;
  bit         e_wv, e_cv, e_cc, e_done;
  logic [4:0] e_w;
  logic [2:0] e_c;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_loading <= 0; m_finished <= 0; m_k <= 0; e_drop <= 0; e_done <= 0;
      e_wv <= 0; e_cv <= 0; e_cc <= 0; e_w <= '0; e_c <= '0;
    end else begin
      e_wv <= 0; e_cv <= 0; e_cc <= 0;
      if (m_loading && in_weight_valid) begin : xfer
        int r, used;
        bit nz;
        r = m_k % SIZE;
        used = 0;
        for (int j = 0; j < r; j++) if (m_col[j][2:0] != 3'd0) used++;
        if (used > MAX_COMP) used = MAX_COMP;
        nz = (in_weight[2:0] != 3'd0);
        m_col[r] <= in_weight;
        e_wv <= 1;
        e_w  <= in_weight[7:3];
        e_c  <= in_weight[2:0];
        e_cv <= nz && (used < MAX_COMP);
        e_cc <= (r == SIZE - 1) && (used < MAX_COMP);
        if (nz && used == MAX_COMP && e_drop < 255) e_drop <= e_drop + 1;
        m_k <= m_k + 1;
        if (m_k == SIZE * SIZE - 1) begin
          m_loading <= 0;
          m_finished <= 1;
        end
      end else if (!m_loading && start) begin
        m_loading <= 1; m_k <= 0; e_drop <= 0; e_done <= 0; m_finished <= 0;
      end else if (m_finished) begin
        e_done <= 1; m_finished <= 0;
      end
    end
  end

  // ---------------- compare process + downstream index model ----------------
  bit   chk_en = 0;
  int   n_wv, n_cv, n_cc, mem_idx;
  int   col_idx [SIZE];
  out_t out_log [$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", {31'd0, in_weight_ready}, {31'd0, m_loading});
      check("w_valid", {31'd0, out_Weight_valid}, {31'd0, e_wv});
      check("c_valid", {31'd0, out_Compensation_valid}, {31'd0, e_cv});
      check("change_col", {31'd0, change_col}, {31'd0, e_cc});
      check("out_weight", {27'd0, out_Weight}, {27'd0, e_w});
      check("comp_weight", {29'd0, Compensation_Weight}, {29'd0, e_c});
      check("done", {31'd0, done}, {31'd0, e_done});
      check("drop_cnt", {24'd0, drop_cnt}, e_drop);
      if (out_Weight_valid) begin
        out_log.push_back('{out_Weight, Compensation_Weight, out_Compensation_valid, change_col});
        // Downstream memory: store at the current index, then align.
        if (change_col) mem_idx = (mem_idx / MAX_COMP + 1) * MAX_COMP;
        else if (out_Compensation_valid) mem_idx++;
        if (n_wv % SIZE == SIZE - 1) col_idx[n_wv / SIZE] = mem_idx;
        n_wv++;
        if (out_Compensation_valid) n_cv++;
        if (change_col) n_cc++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic begin_load();
    n_wv = 0; n_cv = 0; n_cc = 0; mem_idx = 0;
    out_log.delete();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  // gap_mode: 0 none, 1 every other cycle, 2 random. abort_at < 0: full load.
  task automatic drive_load(input load_t w, input int gap_mode, input int abort_at,
                            input bit start_noise);
    int i = 0;
    int cyc = 0;
    bit v, rdy;
    while (i < 64 && i != abort_at && cyc < 1000) begin
      @(negedge clk);
      case (gap_mode)
        0: v = 1;
        1: v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      in_weight       = w[i];
      in_weight_valid = v;
      start           = start_noise && ($urandom_range(0, 15) == 0);
      rdy             = in_weight_ready;
      cyc++;
      if (v && rdy) i++;
    end
    @(negedge clk);
    in_weight_valid = 0;
    start = 0;
    check("load_progress", i, (abort_at < 0) ? 64 : abort_at);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_seen", {31'd0, seen}, 1);
  endtask

  function automatic load_t rand_load();
    load_t w;
    for (int i = 0; i < 64; i++) begin
      w[i] = 8'($urandom);
      if ($urandom_range(0, 1) == 0) w[i][2:0] = 3'd0;
    end
    return w;
  endfunction

  // ---------------- main sequence ----------------
  load_t lw;
  out_t  ref_log [$];

  initial begin
    rst = 0; start = 0; in_weight = '0; in_weight_valid = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    chk_en = 1;
    @(negedge clk);
    check("reset_ready", {31'd0, in_weight_ready}, 0);
    check("reset_done", {31'd0, done}, 0);
    check("reset_drop", {24'd0, drop_cnt}, 0);

    // A: all zero residuals.
    for (int i = 0; i < 64; i++) lw[i] = 8'h08;
    begin_load();
    drive_load(lw, 0, -1, 0);
    wait_done();
    check("A_wv", n_wv, 64);
    check("A_cv", n_cv, 0);
    check("A_cc", n_cc, 8);
    check("A_w", {27'd0, out_log[63].w}, 5'h01);
    check("A_idx", mem_idx, SLOT_GROUP_SIZE);

    // B: column 0 = 01..08, drops on rows 3-6, no change_col on row 7.
    for (int i = 0; i < 64; i++) lw[i] = (i < 8) ? 8'(i + 1) : 8'h08;
    begin_load();
    drive_load(lw, 0, -1, 0);
    wait_done();
    check("B_c0", {29'd0, out_log[0].c}, 1);
    check("B_c2", {29'd0, out_log[2].c}, 3);
    check("B_cv3", {31'd0, out_log[3].cv}, 0);
    check("B_cc7", {31'd0, out_log[7].cc}, 0);
    check("B_drop", {24'd0, drop_cnt}, 4);
    check("B_col0_idx", col_idx[0], 3);
    check("B_cc", n_cc, 7);

    // C: rows 5-7 of column 0 = 05,06,07; column 1 row 2 = 0B.
    for (int i = 0; i < 64; i++) lw[i] = 8'h08;
    lw[5] = 8'h05; lw[6] = 8'h06; lw[7] = 8'h07; lw[10] = 8'h0B;
    begin_load();
    drive_load(lw, 0, -1, 0);
    wait_done();
    check("C_r7_cv", {31'd0, out_log[7].cv}, 1);
    check("C_r7_cc", {31'd0, out_log[7].cc}, 1);
    check("C_r7_c", {29'd0, out_log[7].c}, 7);
    check("C_col0_idx", col_idx[0], 3);
    check("C_r10_cv", {31'd0, out_log[10].cv}, 1);
    check("C_col1_idx", col_idx[1], 6);
    check("C_cv", n_cv, 4);
    check("C_idx", mem_idx, SLOT_GROUP_SIZE);

    // D: random load, gap-free then every-other-cycle; outputs must match.
    lw = rand_load();
    begin_load();
    drive_load(lw, 0, -1, 0);
    wait_done();
    ref_log = out_log;
    begin_load();
    drive_load(lw, 1, -1, 0);
    wait_done();
    check("D_len", out_log.size(), ref_log.size());
    for (int i = 0; i < 64 && i < out_log.size() && i < ref_log.size(); i++)
      if (out_log[i] !== ref_log[i]) check("D_entry", {22'd0, out_log[i], i[7:0]}, {22'd0, ref_log[i], i[7:0]});
    check("D_idx", mem_idx, SLOT_GROUP_SIZE);

    // E: abort after 20 transfers (start pulses during RUN), reset, restart.
    lw = rand_load();
    begin_load();
    drive_load(lw, 2, 20, 1);
    @(negedge clk);
    rst = 0;
    #3 rst = 1;
    @(negedge clk);
    check("E_rst_ready", {31'd0, in_weight_ready}, 0);
    check("E_rst_wv", {31'd0, out_Weight_valid}, 0);
    check("E_rst_drop", {24'd0, drop_cnt}, 0);
    begin_load();
    drive_load(lw, 2, -1, 1);
    wait_done();
    check("E_wv", n_wv, 64);
    check("E_idx", mem_idx, SLOT_GROUP_SIZE);

    // F: a few more random loads with random gaps.
    for (int n = 0; n < 4; n++) begin
      lw = rand_load();
      begin_load();
      drive_load(lw, 2, -1, 1);
      wait_done();
      check("F_idx", mem_idx, SLOT_GROUP_SIZE);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
